jackpot_game_ctrl: RTL and testbench

//  Game sequencer for the 4-LED jackpot board. Generates the LED step rate,

---
 rtl/jackpot_game_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_jackpot_game_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jackpot_game_ctrl.sv
// jackpot_game_ctrl: 4-LED jackpot sequencer -- prescaled lamp rotation, synchronised
// switch hit/miss judging, score/level tracking. Define JACKPOT_LIVES_EN for 3-life games.
module jackpot_game_ctrl #(
  parameter int unsigned TICK_DIV   = 6250000,
  parameter int unsigned SHOW_STEPS = 8,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         switches,
  output logic [3:0]         leds,
  output logic               win,
  output logic [1:0]         level,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic               busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SPIN = 2'd1;
  localparam logic [1:0] ST_WIN  = 2'd2;
  localparam logic [1:0] ST_LOSE = 2'd3;

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = (SHOW_STEPS > 1) ? $clog2(SHOW_STEPS) : 1;

  localparam logic [CW-1:0]      SHOW_LAST  = CW'(SHOW_STEPS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [3:0]         LAMP_FIRST = 4'b0001;
  localparam logic [3:0]         LAMP_ALL   = 4'b1111;

  logic [1:0]         state_q, state_d;
  logic [3:0]         leds_q, leds_d;
  logic               win_q, win_d;
  logic [1:0]         level_q, level_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [CW-1:0]      show_q, show_d;
  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic [3:0]         sync3_q, sync3_d;

`ifdef JACKPOT_LIVES_EN
  logic [1:0]         lives_q, lives_d;
`endif

  logic [3:0]  rise;
  logic [31:0] tick_last;
  logic        step;
  logic        show_done;
  logic        hit;
  logic        miss;

  // Two metastability flops, then an edge register so a held switch fires once.
  always_comb begin
    sync1_d = switches;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise    = sync2_q & ~sync3_q;
  end

  always_comb begin
    tick_last = (TICK_DIV >> level_q) - 32'd1;
    step      = (32'(presc_q) == tick_last);
    show_done = step && (show_q == SHOW_LAST);
    hit       = (state_q == ST_SPIN) && (rise != 4'b0000) && (rise == leds_q);
    miss      = (state_q == ST_SPIN) && (rise != 4'b0000) && (rise != leds_q);
  end

  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    win_d   = 1'b0;
    level_d = level_q;
    score_d = score_q;
    show_d  = show_q;
    presc_d = step ? '0 : presc_q + PW'(1);
`ifdef JACKPOT_LIVES_EN
    lives_d = lives_q;
`endif

    case (state_q)
      ST_IDLE: begin
        leds_d = 4'b0000;
        if (start) begin
          state_d = ST_SPIN;
          leds_d  = LAMP_FIRST;
          score_d = '0;
          level_d = 2'd0;
`ifdef JACKPOT_LIVES_EN
          lives_d = 2'd3;
`endif
        end
      end

      ST_SPIN: begin
        // A judged rise wins over a coincident step, so it sees the pre-step lamp.
        if (hit) begin
          state_d = ST_WIN;
          leds_d  = LAMP_ALL;
          win_d   = 1'b1;
          if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
          if (level_q != 2'd3) level_d = level_q + 2'd1;
        end else if (miss) begin
          state_d = ST_LOSE;
          leds_d  = 4'b0000;
`ifdef JACKPOT_LIVES_EN
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
`endif
        end else if (step) begin
          leds_d = {leds_q[2:0], leds_q[3]};
        end
      end

      ST_WIN: begin
        if (show_done) begin
          state_d = ST_SPIN;
          leds_d  = LAMP_FIRST;
        end else if (step) begin
          show_d = show_q + CW'(1);
        end
      end

      ST_LOSE: begin
        if (show_done) begin
`ifdef JACKPOT_LIVES_EN
          if (lives_q != 2'd0) begin
            state_d = ST_SPIN;
            leds_d  = LAMP_FIRST;
          end else begin
            state_d = ST_IDLE;
            level_d = 2'd0;
          end
`else
          state_d = ST_IDLE;
          level_d = 2'd0;
`endif
        end else if (step) begin
          show_d = show_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        leds_d  = 4'b0000;
      end
    endcase

    // Every phase starts with a full step period and a fresh display count.
    if (state_d != state_q) begin
      presc_d = '0;
      show_d  = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      leds_q  <= 4'b0000;
      win_q   <= 1'b0;
      level_q <= 2'd0;
      score_q <= '0;
      presc_q <= '0;
      show_q  <= '0;
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      sync3_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      win_q   <= win_d;
      level_q <= level_d;
      score_q <= score_d;
      presc_q <= presc_d;
      show_q  <= show_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

`ifdef JACKPOT_LIVES_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lives_q <= 2'd3;
    end else begin
      lives_q <= lives_d;
    end
  end

  assign lives = lives_q;
`else
  assign lives = 2'b00;
`endif

  assign leds  = leds_q;
  assign win   = win_q;
  assign level = level_q;
  assign score = score_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jackpot_game_ctrl.sv
// Scenario bench for jackpot_game_ctrl (TICK_DIV=16, SHOW_STEPS=2, SCORE_W=4); expected
// values come from a rule-level model: lamp index = (clocks in SPIN / period) mod 4.
module tb_jackpot_game_ctrl;

  localparam int TD = 16;
  localparam int SS = 2;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;
`ifdef JACKPOT_LIVES_EN
  localparam bit LIVES = 1'b1;
`else
  localparam bit LIVES = 1'b0;
`endif

  typedef struct packed {
    logic          win_c;
    logic [3:0]    leds_c;
    logic [SW-1:0] score_c;
    logic [1:0]    level_c;
    logic          win_n;
    logic [3:0]    leds_last;
    logic [3:0]    leds_after;
    logic          busy_after;
  } hit_obs_t;

  typedef struct packed {
    logic          win_any;
    logic [3:0]    leds_c;
    logic          busy_c;
    logic [3:0]    leds_last;
    logic          busy_last;
    logic [3:0]    leds_after;
    logic          busy_after;
    logic [1:0]    level_after;
    logic [SW-1:0] score_after;
    logic [1:0]    lives_after;
  } miss_obs_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    switches;
  logic [3:0]    leds;
  logic          win;
  logic [1:0]    level;
  logic [SW-1:0] score;
  logic [1:0]    lives;
  logic          busy;

  int checks = 0;
  int passed = 0;
  int t = 0;
  int m_level = 0;
  int m_score = 0;
  int m_lives = 3;

  jackpot_game_ctrl #(.TICK_DIV(TD), .SHOW_STEPS(SS), .SCORE_W(SW)) dut (
    .clock(clock), .reset(reset), .start(start), .switches(switches),
    .leds(leds), .win(win), .level(level), .score(score), .lives(lives), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "timeout");
  end

  // Lamp shown t clocks after entering SPIN at the given level.
  function automatic logic [3:0] lamp(input int tt, input int lvl);
    logic [3:0] one;
    one = 4'b0001;
    return one << ((tt / (TD >> lvl)) % 4);
  endfunction

  task automatic clk();
    @(posedge clock);
    @(negedge clock);
    t++;
  endtask

  task automatic begin_game();
    reset = 1'b1; start = 1'b0; switches = 4'b0000;
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t = 0; m_level = 0; m_score = 0; m_lives = 3;
  endtask

  // Advance until the lamp judged by a switch raised now (3 clocks later) is idx.
  task automatic wait_lamp(input int idx, input bit boundary);
    int p;
    logic [3:0] one;
    p = TD >> m_level;
    one = 4'b0001;
    if (!boundary) repeat ($urandom_range(0, p - 1)) clk();
    for (int i = 0; i < 8 * p + 8; i++) begin
      if (lamp(t + 2, m_level) == (one << idx) && (!boundary || ((t + 2) % p) == p - 1)) break;
      clk();
    end
  endtask

  task automatic do_hit(input int idx, input bit boundary, input logic [3:0] hold, output hit_obs_t o);
    int p;
    logic [3:0] one;
    one = 4'b0001;
    o = '0;
    wait_lamp(idx, boundary);
    switches = one << idx;
    repeat (3) clk();
    o.win_c = win; o.leds_c = leds; o.score_c = score; o.level_c = level;
    switches = hold;
    m_level = (m_level < 3) ? m_level + 1 : 3;
    m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
    p = TD >> m_level;
    clk();
    o.win_n = win;
    repeat (SS * p - 2) clk();
    o.leds_last = leds;
    clk();
    o.leds_after = leds; o.busy_after = busy;
    t = 0;
  endtask

  task automatic do_miss(input int idx, input bit boundary, input logic [3:0] mask, output miss_obs_t o);
    int p;
    o = '0;
    wait_lamp(idx, boundary);
    switches = mask;
    repeat (3) begin
      clk();
      o.win_any = o.win_any | win;
    end
    o.leds_c = leds; o.busy_c = busy;
    switches = 4'b0000;
    p = TD >> m_level;
    repeat (SS * p - 1) begin
      clk();
      o.win_any = o.win_any | win;
    end
    o.leds_last = leds; o.busy_last = busy;
    clk();
    o.leds_after = leds; o.busy_after = busy; o.level_after = level;
    o.score_after = score; o.lives_after = lives;
    if (LIVES) m_lives--;
    if (!(LIVES && m_lives > 0)) m_level = 0;
    t = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; switches = 4'b0000;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    checks++; if (leds !== 4'b0000) $display("FAIL reset_leds got %b want 0000", leds); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (score !== '0) $display("FAIL reset_score got %0d want 0", score); else passed++;
    checks++; if (level !== 2'd0) $display("FAIL reset_level got %0d want 0", level); else passed++;
    checks++; if (win !== 1'b0) $display("FAIL reset_win got %b want 0", win); else passed++;
    checks++; if (lives !== (LIVES ? 2'd3 : 2'd0)) $display("FAIL reset_lives got %0d want %0d", lives, LIVES ? 3 : 0); else passed++;
  endtask

  task automatic test_rotation();
    begin_game();
    checks++; if (busy !== 1'b1) $display("FAIL rot_busy got %b want 1", busy); else passed++;
    for (int k = 0; k < 70; k++) begin
      checks++; if (leds !== lamp(t, 0)) $display("FAIL rot_t%0d got %b want %b", t, leds, lamp(t, 0)); else passed++;
      clk();
    end
  endtask

  task automatic test_hit();
    hit_obs_t o;
    begin_game();
    do_hit(2, 1'b0, 4'b0000, o);
    checks++; if (o.win_c !== 1'b1) $display("FAIL hit_win got %b want 1", o.win_c); else passed++;
    checks++; if (o.leds_c !== 4'b1111) $display("FAIL hit_leds got %b want 1111", o.leds_c); else passed++;
    checks++; if (o.score_c !== 4'd1) $display("FAIL hit_score got %0d want 1", o.score_c); else passed++;
    checks++; if (o.level_c !== 2'd1) $display("FAIL hit_level got %0d want 1", o.level_c); else passed++;
    checks++; if (o.win_n !== 1'b0) $display("FAIL hit_win_pulse got %b want 0", o.win_n); else passed++;
    checks++; if (o.leds_last !== 4'b1111) $display("FAIL hit_show_hold got %b want 1111", o.leds_last); else passed++;
    checks++; if (o.leds_after !== 4'b0001) $display("FAIL hit_respin got %b want 0001", o.leds_after); else passed++;
    for (int k = 0; k < 40; k++) begin
      checks++; if (leds !== lamp(t, 1)) $display("FAIL lvl1_t%0d got %b want %b", t, leds, lamp(t, 1)); else passed++;
      clk();
    end
  endtask

  task automatic test_miss();
    hit_obs_t h;
    miss_obs_t o;
    bit alive;
    begin_game();
    do_hit(1, 1'b0, 4'b0000, h);
    do_miss(2, 1'b0, 4'b0001, o);
    alive = LIVES && (m_lives > 0);
    checks++; if (o.win_any !== 1'b0) $display("FAIL miss_win got %b want 0", o.win_any); else passed++;
    checks++; if (o.leds_c !== 4'b0000) $display("FAIL miss_leds got %b want 0000", o.leds_c); else passed++;
    checks++; if (o.busy_c !== 1'b1) $display("FAIL miss_busy got %b want 1", o.busy_c); else passed++;
    checks++; if (o.leds_last !== 4'b0000 || o.busy_last !== 1'b1) $display("FAIL miss_hold got %b/%b want 0000/1", o.leds_last, o.busy_last); else passed++;
    checks++; if (o.busy_after !== alive) $display("FAIL miss_end_busy got %b want %b", o.busy_after, alive); else passed++;
    checks++; if (o.leds_after !== (alive ? 4'b0001 : 4'b0000)) $display("FAIL miss_end_leds got %b want %b", o.leds_after, alive ? 4'b0001 : 4'b0000); else passed++;
    checks++; if (o.level_after !== (alive ? 2'd1 : 2'd0)) $display("FAIL miss_end_level got %0d want %0d", o.level_after, alive ? 1 : 0); else passed++;
    checks++; if (o.score_after !== 4'd1) $display("FAIL miss_score_held got %0d want 1", o.score_after); else passed++;
    checks++; if (o.lives_after !== (LIVES ? 2'd2 : 2'd0)) $display("FAIL miss_lives got %0d want %0d", o.lives_after, LIVES ? 2 : 0); else passed++;
  endtask

  task automatic test_multi_bit_miss();
    miss_obs_t o;
    begin_game();
    do_miss(1, 1'b0, 4'b1010, o);
    checks++; if (o.win_any !== 1'b0) $display("FAIL multi_win got %b want 0", o.win_any); else passed++;
    checks++; if (o.leds_c !== 4'b0000) $display("FAIL multi_leds got %b want 0000", o.leds_c); else passed++;
    checks++; if (o.score_after !== 4'd0) $display("FAIL multi_score got %0d want 0", o.score_after); else passed++;
  endtask

  task automatic test_step_boundary();
    hit_obs_t h;
    miss_obs_t o;
    int idx;
    logic [3:0] nxt;
    begin_game();
    do_hit(int'($urandom_range(0, 3)), 1'b1, 4'b0000, h);
    checks++; if (h.win_c !== 1'b1 || h.leds_c !== 4'b1111) $display("FAIL edge_hit got %b/%b want 1/1111", h.win_c, h.leds_c); else passed++;
    begin_game();
    idx = int'($urandom_range(0, 3));
    nxt = 4'b0001;
    nxt = nxt << ((idx + 1) % 4);
    do_miss(idx, 1'b1, nxt, o);
    checks++; if (o.leds_c !== 4'b0000 || o.win_any !== 1'b0) $display("FAIL edge_miss got %b/%b want 0000/0", o.leds_c, o.win_any); else passed++;
  endtask

  task automatic test_back_to_back();
    hit_obs_t o;
    begin_game();
    for (int h = 0; h < 5; h++) begin
      do_hit(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'b0000, o);
      checks++; if (o.win_c !== 1'b1) $display("FAIL b2b_win%0d got %b want 1", h, o.win_c); else passed++;
      checks++; if (o.score_c !== SW'(m_score) || o.level_c !== 2'(m_level)) $display("FAIL b2b_sl%0d got %0d/%0d want %0d/%0d", h, o.score_c, o.level_c, m_score, m_level); else passed++;
    end
    checks++; if (level !== 2'd3 || score !== 4'd5) $display("FAIL b2b_final got %0d/%0d want 3/5", level, score); else passed++;
    for (int k = 0; k < 20; k++) begin
      checks++; if (leds !== lamp(t, 3)) $display("FAIL lvl3_t%0d got %b want %b", t, leds, lamp(t, 3)); else passed++;
      clk();
    end
  endtask

  task automatic test_saturation();
    hit_obs_t o;
    begin_game();
    repeat (SMAX + 2) do_hit(int'($urandom_range(0, 3)), 1'b0, 4'b0000, o);
    checks++; if (score !== SW'(SMAX)) $display("FAIL sat_score got %0d want %0d", score, SMAX); else passed++;
    checks++; if (o.win_c !== 1'b1 || level !== 2'd3) $display("FAIL sat_win_level got %b/%0d want 1/3", o.win_c, level); else passed++;
  endtask

  task automatic test_win_ignores_rise();
    hit_obs_t o;
    begin_game();
    do_hit(2, 1'b0, 4'b0001, o);
    checks++; if (o.leds_after !== 4'b0001) $display("FAIL ign_respin got %b want 0001", o.leds_after); else passed++;
    for (int k = 0; k < 24; k++) begin
      checks++; if (leds !== lamp(t, m_level) || busy !== 1'b1) $display("FAIL ign_t%0d got %b want %b", t, leds, lamp(t, m_level)); else passed++;
      clk();
    end
    switches = 4'b0000;
    clk(); clk();
    do_hit(0, 1'b0, 4'b0000, o);
    checks++; if (o.win_c !== 1'b1 || o.score_c !== 4'd2) $display("FAIL ign_rearm got %b/%0d want 1/2", o.win_c, o.score_c); else passed++;
  endtask

  task automatic test_reset_mid_win();
    begin_game();
    wait_lamp(1, 1'b0);
    switches = 4'b0010;
    repeat (3) clk();
    checks++; if (leds !== 4'b1111) $display("FAIL rst_in_win got %b want 1111", leds); else passed++;
    clk(); clk();
    #2 reset = 1'b1;
    #1;
    checks++; if (leds !== 4'b0000 || busy !== 1'b0) $display("FAIL rst_async got %b/%b want 0000/0", leds, busy); else passed++;
    checks++; if (score !== '0 || level !== 2'd0 || win !== 1'b0) $display("FAIL rst_regs got %0d/%0d/%b want 0/0/0", score, level, win); else passed++;
    @(negedge clock);
    reset = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++; if (leds !== 4'b0001) $display("FAIL rel_spin got %b want 0001", leds); else passed++;
    @(negedge clock);
    checks++; if (leds !== 4'b0001 || busy !== 1'b1) $display("FAIL rel_early got %b/%b want 0001/1", leds, busy); else passed++;
    @(negedge clock);
    checks++; if (leds !== 4'b0000 || busy !== 1'b1) $display("FAIL rel_rise got %b/%b want 0000/1", leds, busy); else passed++;
    switches = 4'b0000;
  endtask

  task automatic test_reset_release();
    reset = 1'b1; start = 1'b0; switches = 4'b0100;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    checks++; if (busy !== 1'b0) $display("FAIL relidle_busy got %b want 0", busy); else passed++;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    t = 0; m_level = 0;
    for (int k = 0; k < 40; k++) begin
      checks++; if (leds !== lamp(t, 0)) $display("FAIL held_t%0d got %b want %b", t, leds, lamp(t, 0)); else passed++;
      clk();
    end
    switches = 4'b0000;
  endtask

  task automatic test_random_games();
    hit_obs_t h;
    miss_obs_t o;
    int nh;
    int idx;
    logic [3:0] mask;
    logic [3:0] one;
    bit alive;
    one = 4'b0001;
    for (int g = 0; g < 6; g++) begin
      begin_game();
      nh = int'($urandom_range(0, 3));
      for (int i = 0; i < nh; i++) begin
        do_hit(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'b0000, h);
        checks++; if (h.win_c !== 1'b1 || h.score_c !== SW'(m_score)) $display("FAIL rnd%0d_hit%0d got %b/%0d want 1/%0d", g, i, h.win_c, h.score_c, m_score); else passed++;
      end
      idx = int'($urandom_range(0, 3));
      mask = 4'($urandom_range(1, 15));
      while (mask == (one << idx)) mask = 4'($urandom_range(1, 15));
      do_miss(idx, 1'b0, mask, o);
      alive = LIVES && (m_lives > 0);
      checks++; if (o.leds_c !== 4'b0000 || o.win_any !== 1'b0) $display("FAIL rnd%0d_miss got %b/%b want 0000/0", g, o.leds_c, o.win_any); else passed++;
      checks++; if (o.busy_after !== alive || o.level_after !== 2'(m_level)) $display("FAIL rnd%0d_end got %b/%0d want %b/%0d", g, o.busy_after, o.level_after, alive, m_level); else passed++;
      checks++; if (o.score_after !== SW'(m_score)) $display("FAIL rnd%0d_score got %0d want %0d", g, o.score_after, m_score); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_hit();
    test_miss();
    test_multi_bit_miss();
    test_step_boundary();
    test_back_to_back();
    test_saturation();
    test_win_ignores_rise();
    test_reset_mid_win();
    test_reset_release();
    test_random_games();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
